// File: rtl/rvfi_seq_pkg.sv
// Shared definitions for the RVFI order sequencer.
// Holds the default widths and window depth, the derived slot-index width,
// and the retirement entry record used by anything that consumes the
// sequencer's single-channel output in its default configuration.
package rvfi_seq_pkg;

    localparam int DEF_NRET    = 2;
    localparam int DEF_XLEN    = 32;
    localparam int DEF_ORDER_W = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int SLOT_W      = $clog2(DEF_DEPTH);

    // One retired instruction as seen by a single-channel checker.
    typedef struct packed {
        logic [DEF_ORDER_W-1:0] order;
        logic [31:0]            insn;
        logic                   trap;
        logic [DEF_XLEN-1:0]    pc_rdata;
        logic [DEF_XLEN-1:0]    pc_wdata;
    } rvfi_entry_t;

endpackage

// File: rtl/rvfi_order_window.sv
// Per-channel window lookup for the RVFI order sequencer (combinational).
// Given one channel's order and the next order to emit, reports which
// reorder slot the entry maps to, whether the order lies inside the window,
// and whether that slot is already holding an entry.
// Ports:
//   order      in  ORDER_W  incoming instruction order
//   exp_order  in  ORDER_W  next order to be emitted (head)
//   slot_valid in  DEPTH    current slot occupancy flags
//   slot       out SLOT     slot index = order mod DEPTH
//   in_window  out 1        (order - exp_order) mod 2^ORDER_W < DEPTH
//   occupied   out 1        the mapped slot is already valid
module rvfi_order_window
    import rvfi_seq_pkg::*;
#(
    parameter int ORDER_W = DEF_ORDER_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic [ORDER_W-1:0]         order,
    input  logic [ORDER_W-1:0]         exp_order,
    input  logic [DEPTH-1:0]           slot_valid,
    output logic [$clog2(DEPTH)-1:0]   slot,
    output logic                       in_window,
    output logic                       occupied
);

    localparam int SW = $clog2(DEPTH);

    // Distance ahead of the head; the subtraction wraps naturally.
    logic [ORDER_W-1:0] dist_s;

    assign dist_s    = order - exp_order;
    assign in_window = (dist_s < ORDER_W'(DEPTH));
    // DEPTH is a power of two, so the low bits are the modulo.
    assign slot      = order[SW-1:0];
    assign occupied  = slot_valid[slot];

endmodule

// File: rtl/rvfi_order_sequencer.sv
// RVFI order sequencer: collects up to NRET retirements per cycle from a
// multi-retire core, parks them in a reorder window indexed by order, and
// hands them out one at a time in strictly increasing order on a
// valid/ready channel. Out-of-window and duplicate/colliding entries are
// dropped and flagged with sticky error bits; operation continues.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   rvfi_valid/order/insn/trap/pc_rdata/pc_wdata   NRET packed input channels
//   out_valid, out_ready        head handshake
//   out_order/insn/trap/pc_rdata/pc_wdata          head payload
//   occupancy                   number of buffered entries
//   err_window, err_dup         sticky error flags
module rvfi_order_sequencer
    import rvfi_seq_pkg::*;
#(
    parameter int NRET    = DEF_NRET,
    parameter int XLEN    = DEF_XLEN,
    parameter int ORDER_W = DEF_ORDER_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NRET-1:0]            rvfi_valid,
    input  logic [NRET*ORDER_W-1:0]    rvfi_order,
    input  logic [NRET*32-1:0]         rvfi_insn,
    input  logic [NRET-1:0]            rvfi_trap,
    input  logic [NRET*XLEN-1:0]       rvfi_pc_rdata,
    input  logic [NRET*XLEN-1:0]       rvfi_pc_wdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ORDER_W-1:0]         out_order,
    output logic [31:0]                out_insn,
    output logic                       out_trap,
    output logic [XLEN-1:0]            out_pc_rdata,
    output logic [XLEN-1:0]            out_pc_wdata,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err_window,
    output logic                       err_dup
);

    localparam int SW = $clog2(DEPTH);
    localparam int CW = SW + 1;

    // Window state
    logic [DEPTH-1:0]   slot_valid_r;
    logic [ORDER_W-1:0] slot_order_r    [DEPTH];
    logic [31:0]        slot_insn_r     [DEPTH];
    logic               slot_trap_r     [DEPTH];
    logic [XLEN-1:0]    slot_pc_rdata_r [DEPTH];
    logic [XLEN-1:0]    slot_pc_wdata_r [DEPTH];
    logic [ORDER_W-1:0] exp_order_r;
    logic [CW-1:0]      occupancy_r;
    logic               err_window_r;
    logic               err_dup_r;

    // Per-channel window lookup results
    logic [SW-1:0]      ch_slot_s      [NRET];
    logic [NRET-1:0]    ch_in_window_s;
    logic [NRET-1:0]    ch_occupied_s;

    // Per-slot write decisions for this edge
    logic [DEPTH-1:0]   wr_en_s;
    logic [ORDER_W-1:0] wr_order_s    [DEPTH];
    logic [31:0]        wr_insn_s     [DEPTH];
    logic               wr_trap_s     [DEPTH];
    logic [XLEN-1:0]    wr_pc_rdata_s [DEPTH];
    logic [XLEN-1:0]    wr_pc_wdata_s [DEPTH];
    logic [CW-1:0]      ins_cnt_s;
    logic               set_window_s;
    logic               set_dup_s;

    logic [SW-1:0]      head_s;
    logic               pop_s;

    genvar gc;
    generate
        for (gc = 0; gc < NRET; gc++) begin : g_win
            rvfi_order_window #(
                .ORDER_W (ORDER_W),
                .DEPTH   (DEPTH)
            ) u_win (
                .order      (rvfi_order[gc*ORDER_W +: ORDER_W]),
                .exp_order  (exp_order_r),
                .slot_valid (slot_valid_r),
                .slot       (ch_slot_s[gc]),
                .in_window  (ch_in_window_s[gc]),
                .occupied   (ch_occupied_s[gc])
            );
        end
    endgenerate

    assign head_s = exp_order_r[SW-1:0];
    assign pop_s  = slot_valid_r[head_s] & out_ready;

    // Insertion arbitration: channels are scanned low to high so the lowest
    // channel claims a free slot first; any later claimant of the same slot
    // is a collision. All checks use pre-edge state, so a slot freed by a
    // same-cycle pop is never reused in that cycle.
    always_comb begin
        wr_en_s      = '0;
        ins_cnt_s    = '0;
        set_window_s = 1'b0;
        set_dup_s    = 1'b0;
        for (int s = 0; s < DEPTH; s++) begin
            wr_order_s[s]    = '0;
            wr_insn_s[s]     = '0;
            wr_trap_s[s]     = 1'b0;
            wr_pc_rdata_s[s] = '0;
            wr_pc_wdata_s[s] = '0;
        end
        for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c]) begin
                if (!ch_in_window_s[c]) begin
                    set_window_s = 1'b1;
                end else if (ch_occupied_s[c] || wr_en_s[ch_slot_s[c]]) begin
                    set_dup_s = 1'b1;
                end else begin
                    wr_en_s[ch_slot_s[c]]       = 1'b1;
                    wr_order_s[ch_slot_s[c]]    = rvfi_order[c*ORDER_W +: ORDER_W];
                    wr_insn_s[ch_slot_s[c]]     = rvfi_insn[c*32 +: 32];
                    wr_trap_s[ch_slot_s[c]]     = rvfi_trap[c];
                    wr_pc_rdata_s[ch_slot_s[c]] = rvfi_pc_rdata[c*XLEN +: XLEN];
                    wr_pc_wdata_s[ch_slot_s[c]] = rvfi_pc_wdata[c*XLEN +: XLEN];
                    ins_cnt_s                   = ins_cnt_s + CW'(1);
                end
            end else begin
                // idle channel: nothing to insert
                set_window_s = set_window_s;
            end
        end
    end

    // Control state: slot flags, head pointer, occupancy count, sticky errors.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slot_valid_r <= '0;
            exp_order_r  <= '0;
            occupancy_r  <= '0;
            err_window_r <= 1'b0;
            err_dup_r    <= 1'b0;
        end else begin
            // A write never targets the head while it is valid (it would be
            // a duplicate), so set and clear cannot hit the same slot.
            for (int s = 0; s < DEPTH; s++) begin
                if (wr_en_s[s]) begin
                    slot_valid_r[s] <= 1'b1;
                end else if (pop_s && (SW'(s) == head_s)) begin
                    slot_valid_r[s] <= 1'b0;
                end
            end
            if (pop_s) begin
                exp_order_r <= exp_order_r + ORDER_W'(1);
            end
            occupancy_r  <= occupancy_r + ins_cnt_s - CW'(pop_s);
            err_window_r <= err_window_r | set_window_s;
            err_dup_r    <= err_dup_r | set_dup_s;
        end
    end

    // Payload storage: written on insertion only, deliberately not reset.
    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (wr_en_s[s]) begin
                slot_order_r[s]    <= wr_order_s[s];
                slot_insn_r[s]     <= wr_insn_s[s];
                slot_trap_r[s]     <= wr_trap_s[s];
                slot_pc_rdata_r[s] <= wr_pc_rdata_s[s];
                slot_pc_wdata_r[s] <= wr_pc_wdata_s[s];
            end
        end
    end

    // Head view: a mux over registered slots, so it is stable while stalled.
    assign out_valid    = slot_valid_r[head_s];
    assign out_order    = slot_order_r[head_s];
    assign out_insn     = slot_insn_r[head_s];
    assign out_trap     = slot_trap_r[head_s];
    assign out_pc_rdata = slot_pc_rdata_r[head_s];
    assign out_pc_wdata = slot_pc_wdata_r[head_s];
    assign occupancy    = occupancy_r;
    assign err_window   = err_window_r;
    assign err_dup      = err_dup_r;

endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Scoreboard bench for rvfi_order_sequencer (NRET=2, XLEN=32, ORDER_W=8,
// DEPTH=8). Stimulus pushes expected entries into a queue; a monitor pops
// and compares on every output handshake.
module tb_rvfi_order_sequencer;
    import rvfi_seq_pkg::*;

    logic        clk;
    logic        resetn;
    logic [1:0]  rvfi_valid;
    logic [15:0] rvfi_order;
    logic [63:0] rvfi_insn;
    logic [1:0]  rvfi_trap;
    logic [63:0] rvfi_pc_rdata;
    logic [63:0] rvfi_pc_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_order;
    logic [31:0] out_insn;
    logic        out_trap;
    logic [31:0] out_pc_rdata;
    logic [31:0] out_pc_wdata;
    logic [3:0]  occupancy;
    logic        err_window;
    logic        err_dup;

    int          n_pass;
    int          n_total;
    rvfi_entry_t sb[$];

    rvfi_order_sequencer #(
        .NRET(2), .XLEN(32), .ORDER_W(8), .DEPTH(8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .rvfi_valid    (rvfi_valid),
        .rvfi_order    (rvfi_order),
        .rvfi_insn     (rvfi_insn),
        .rvfi_trap     (rvfi_trap),
        .rvfi_pc_rdata (rvfi_pc_rdata),
        .rvfi_pc_wdata (rvfi_pc_wdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_order     (out_order),
        .out_insn      (out_insn),
        .out_trap      (out_trap),
        .out_pc_rdata  (out_pc_rdata),
        .out_pc_wdata  (out_pc_wdata),
        .occupancy     (occupancy),
        .err_window    (err_window),
        .err_dup       (err_dup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Channel-dependent payload so a wrong channel winner is visible.
    function automatic rvfi_entry_t mk(input int ch, input int ord);
        rvfi_entry_t e;
        e.order    = 8'(ord);
        e.insn     = {16'h0013, 8'(ch), 8'(ord)};
        e.trap     = ((ord % 5) == 0) ? 1'b1 : 1'b0;
        e.pc_rdata = 32'h8000_0000 + 32'(ord * 4) + 32'(ch * 65536);
        e.pc_wdata = e.pc_rdata + 32'h4 + 32'(ch * 1048576);
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic set_ch(input int ch, input int ord);
        rvfi_entry_t e;
        e = mk(ch, ord);
        rvfi_valid[ch]              = 1'b1;
        rvfi_order[ch*8 +: 8]       = e.order;
        rvfi_insn[ch*32 +: 32]      = e.insn;
        rvfi_trap[ch]               = e.trap;
        rvfi_pc_rdata[ch*32 +: 32]  = e.pc_rdata;
        rvfi_pc_wdata[ch*32 +: 32]  = e.pc_wdata;
    endtask

    task automatic clr_in();
        rvfi_valid = 2'b00;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        sb.delete();
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        rvfi_entry_t e;
        if (resetn && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got order %0h expected none", out_order);
            end else begin
                e = sb.pop_front();
                check("out_order",    64'(out_order),    64'(e.order));
                check("out_insn",     64'(out_insn),     64'(e.insn));
                check("out_trap",     64'(out_trap),     64'(e.trap));
                check("out_pc_rdata", 64'(out_pc_rdata), 64'(e.pc_rdata));
                check("out_pc_wdata", 64'(out_pc_wdata), 64'(e.pc_wdata));
            end
        end
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        resetn = 1'b0;
        out_ready = 1'b0;
        rvfi_valid = '0;
        rvfi_order = '0;
        rvfi_insn = '0;
        rvfi_trap = '0;
        rvfi_pc_rdata = '0;
        rvfi_pc_wdata = '0;

        // Reset state
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_err_window", 64'(err_window), 64'd0);
        check("rst_err_dup", 64'(err_dup), 64'd0);

        // Two in-order retirements in one cycle
        out_ready = 1'b1;
        sb.push_back(mk(0, 0));
        sb.push_back(mk(1, 1));
        set_ch(0, 0); set_ch(1, 1); cyc(); clr_in();
        check("t1_occ2", 64'(occupancy), 64'd2);
        cyc();
        check("t1_occ1", 64'(occupancy), 64'd1);
        cyc();
        check("t1_occ0", 64'(occupancy), 64'd0);
        check("t1_empty", 64'(out_valid), 64'd0);

        // Out-of-order arrival 2, 0, 1
        do_reset();
        out_ready = 1'b1;
        sb.push_back(mk(1, 0));
        sb.push_back(mk(0, 1));
        sb.push_back(mk(0, 2));
        set_ch(0, 2); cyc(); clr_in();
        check("t2_no_head", 64'(out_valid), 64'd0);
        check("t2_occ1", 64'(occupancy), 64'd1);
        set_ch(1, 0); cyc(); clr_in();
        check("t2_head", 64'(out_valid), 64'd1);
        set_ch(0, 1); cyc(); clr_in();
        check("t2_pop_ins", 64'(occupancy), 64'd2);
        cyc();
        cyc();
        check("t2_occ0", 64'(occupancy), 64'd0);

        // Fill the window while stalled, then overflow by one
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(mk(0, 2*k));
            sb.push_back(mk(1, 2*k + 1));
            set_ch(0, 2*k); set_ch(1, 2*k + 1); cyc(); clr_in();
        end
        check("t3_full", 64'(occupancy), 64'd8);
        set_ch(0, 8); cyc(); clr_in();
        check("t3_err_window", 64'(err_window), 64'd1);
        check("t3_err_dup", 64'(err_dup), 64'd0);
        check("t3_occ", 64'(occupancy), 64'd8);
        check("t3_hold_order", 64'(out_order), 64'd0);
        check("t3_hold_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (9) cyc();
        check("t3_drained", 64'(occupancy), 64'd0);
        check("t3_no_eight", 64'(out_valid), 64'd0);

        // Same-cycle collision on order 3
        do_reset();
        out_ready = 1'b0;
        set_ch(0, 0); set_ch(1, 1); cyc(); clr_in();
        set_ch(0, 3); set_ch(1, 3); cyc(); clr_in();
        check("t4_err_dup", 64'(err_dup), 64'd1);
        check("t4_err_window", 64'(err_window), 64'd0);
        check("t4_occ", 64'(occupancy), 64'd3);
        set_ch(0, 2); cyc(); clr_in();
        sb.push_back(mk(0, 0));
        sb.push_back(mk(1, 1));
        sb.push_back(mk(0, 2));
        sb.push_back(mk(0, 3));
        out_ready = 1'b1;
        repeat (5) cyc();
        check("t4_occ0", 64'(occupancy), 64'd0);

        // 300 in-order retirements across the order wrap
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sb.push_back(mk(i % 2, i % 256));
            set_ch(i % 2, i % 256); cyc(); clr_in();
        end
        repeat (2) cyc();
        check("t5_err_window", 64'(err_window), 64'd0);
        check("t5_err_dup", 64'(err_dup), 64'd0);
        check("t5_occ0", 64'(occupancy), 64'd0);

        // Asynchronous reset with 5 buffered entries and a sticky error
        do_reset();
        out_ready = 1'b0;
        set_ch(0, 0); set_ch(1, 1); cyc(); clr_in();
        set_ch(0, 2); set_ch(1, 3); cyc(); clr_in();
        set_ch(0, 4); set_ch(1, 100); cyc(); clr_in();
        check("t6_occ5", 64'(occupancy), 64'd5);
        check("t6_err_set", 64'(err_window), 64'd1);
        #2;
        resetn = 1'b0;
        sb.delete();
        #1;
        check("t6_async_valid", 64'(out_valid), 64'd0);
        check("t6_async_occ", 64'(occupancy), 64'd0);
        check("t6_async_errw", 64'(err_window), 64'd0);
        check("t6_async_errd", 64'(err_dup), 64'd0);
        cyc();
        resetn = 1'b1;
        out_ready = 1'b1;
        sb.push_back(mk(1, 0));
        set_ch(1, 0); cyc(); clr_in();
        check("t6_accept", 64'(occupancy), 64'd1);
        cyc();
        check("t6_occ0", 64'(occupancy), 64'd0);

        repeat (2) cyc();
        check("drain", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
